// File: rtl/alu_issue.sv
// alu_issue -- execute-stage sequencer for an RV32E core.
//
// Accepts one OP / OP-IMM instruction at a time, reads its operands from an
// internal 16-entry register file, drives a combinational ALU, captures the
// result and writes it back to rd. Sequence: IDLE -> EXEC -> WB -> IDLE.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   instr_valid/instr_ready  instruction handshake (ready only in IDLE)
//   instr                    32-bit instruction word
//   alu_value1/alu_value2    ALU operands (rs1, rs2 or sign-extended imm)
//   alu_func_type            func3 of the instruction
//   alu_f7_bit               selects SUB / SRA in the ALU
//   alu_result               combinational ALU result
//   done/illegal             one-cycle completion pulses (illegal with done)
//   done_rd/done_value       destination index and written value (0 if illegal)
//   dbg_addr/dbg_data        combinational register file debug read
//
// Configuration macro: ALU_ISSUE_STRICT_F7_EN -- when defined, funct7 is fully
// checked and non-conforming encodings are reported as illegal.

module alu_issue #(
    parameter int size = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instr,
    output logic [size-1:0] alu_value1,
    output logic [size-1:0] alu_value2,
    output logic [2:0]      alu_func_type,
    output logic            alu_f7_bit,
    input  logic [size-1:0] alu_result,
    output logic            done,
    output logic            illegal,
    output logic [3:0]      done_rd,
    output logic [size-1:0] done_value,
    input  logic [3:0]      dbg_addr,
    output logic [size-1:0] dbg_data
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t          state;
    logic [size-1:0] regs [16];   // entry 0 is never written, so x0 reads 0
    logic [3:0]      rd_q;
    logic            ill_q;

    // Instruction field decode.
    logic [6:0]      opcode;
    logic [4:0]      rd_f, rs1_f, rs2_f;
    logic [2:0]      f3;
    logic            is_op, is_imm;
    logic            dec_illegal;
    logic            dec_f7;
    logic [size-1:0] dec_op2;

    assign opcode = instr[6:0];
    assign rd_f   = instr[11:7];
    assign f3     = instr[14:12];
    assign rs1_f  = instr[19:15];
    assign rs2_f  = instr[24:20];
    assign is_op  = (opcode == OPC_OP);
    assign is_imm = (opcode == OPC_OP_IMM);

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        dec_illegal = 1'b0;
        dec_f7      = 1'b0;

        if (!(is_op || is_imm))
            dec_illegal = 1'b1;
        // RV32E has only x0..x15; bit 4 of any used register index is illegal.
        if (rd_f[4] || rs1_f[4] || (is_op && rs2_f[4]))
            dec_illegal = 1'b1;

        // instr[30] only reaches the ALU where it means SUB or SRA, so an
        // immediate with bit 30 set (e.g. ADDI) never subtracts.
        if (is_op && (f3 == 3'b000 || f3 == 3'b101))
            dec_f7 = instr[30];
        else if (is_imm && f3 == 3'b101)
            dec_f7 = instr[30];

`ifdef ALU_ISSUE_STRICT_F7_EN
        if (is_op && !(instr[31:25] == 7'b0000000 ||
                       (instr[31:25] == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))))
            dec_illegal = 1'b1;
        if (is_imm && f3 == 3'b001 && instr[31:25] != 7'b0000000)
            dec_illegal = 1'b1;
        if (is_imm && f3 == 3'b101 &&
            !(instr[31:25] == 7'b0000000 || instr[31:25] == 7'b0100000))
            dec_illegal = 1'b1;
`endif
    end

    // Operand 2: rs2 for OP, sign-extended 12-bit immediate for OP-IMM.
    assign dec_op2 = is_op ? regs[rs2_f[3:0]]
                           : {{(size-12){instr[31]}}, instr[31:20]};

    assign instr_ready = (state == IDLE);
    assign dbg_data    = regs[dbg_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            rd_q          <= '0;
            ill_q         <= 1'b0;
            alu_value1    <= '0;
            alu_value2    <= '0;
            alu_func_type <= '0;
            alu_f7_bit    <= 1'b0;
            done          <= 1'b0;
            illegal       <= 1'b0;
            done_rd       <= '0;
            done_value    <= '0;
            // NOTE: the register file is architecturally cleared by reset, so
            // this storage is built from resettable flops rather than a RAM.
            for (int i = 0; i < 16; i++)
                regs[i] <= '0;
        end else begin
            // NOTE: all state here uses non-blocking assignment so every
            // register samples pre-edge values regardless of statement order.
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        rd_q          <= rd_f[3:0];
                        ill_q         <= dec_illegal;
                        alu_value1    <= regs[rs1_f[3:0]];
                        alu_value2    <= dec_op2;
                        alu_func_type <= f3;
                        alu_f7_bit    <= dec_f7;
                        state         <= EXEC;
                    end
                end
                EXEC: begin
                    // done_value doubles as the result register feeding writeback.
                    done       <= 1'b1;
                    illegal    <= ill_q;
                    done_rd    <= rd_q;
                    done_value <= ill_q ? '0 : alu_result;
                    state      <= WB;
                end
                WB: begin
                    done    <= 1'b0;
                    illegal <= 1'b0;
                    if (!ill_q && rd_q != 4'd0)
                        regs[rd_q] <= done_value;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
`timescale 1ns/100ps

module tb_alu_issue;

    localparam int size = 32;

    logic            clk;
    logic            rst;
    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instr;
    logic [size-1:0] alu_value1;
    logic [size-1:0] alu_value2;
    logic [2:0]      alu_func_type;
    logic            alu_f7_bit;
    logic [size-1:0] alu_result;
    logic            done;
    logic            illegal;
    logic [3:0]      done_rd;
    logic [size-1:0] done_value;
    logic [3:0]      dbg_addr;
    logic [size-1:0] dbg_data;

    alu_issue #(.size(size)) dut (
        .clk           (clk),
        .rst           (rst),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .alu_value1    (alu_value1),
        .alu_value2    (alu_value2),
        .alu_func_type (alu_func_type),
        .alu_f7_bit    (alu_f7_bit),
        .alu_result    (alu_result),
        .done          (done),
        .illegal       (illegal),
        .done_rd       (done_rd),
        .done_value    (done_value),
        .dbg_addr      (dbg_addr),
        .dbg_data      (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference RV32I integer ALU on the other side of the interface.
    always_comb begin
        case (alu_func_type)
            3'b000:  alu_result = alu_f7_bit ? alu_value1 - alu_value2 : alu_value1 + alu_value2;
            3'b001:  alu_result = alu_value1 << alu_value2[4:0];
            3'b010:  alu_result = {31'd0, $signed(alu_value1) < $signed(alu_value2)};
            3'b011:  alu_result = {31'd0, alu_value1 < alu_value2};
            3'b100:  alu_result = alu_value1 ^ alu_value2;
            3'b101:  alu_result = alu_f7_bit ? 32'($signed(alu_value1) >>> alu_value2[4:0])
                                             : alu_value1 >> alu_value2[4:0];
            3'b110:  alu_result = alu_value1 | alu_value2;
            default: alu_result = alu_value1 & alu_value2;
        endcase
    end

    int total;
    int passed;
    logic [31:0] exp_regs [16];

    // Observations captured by run_instr.
    logic        exec_done, wb_done, wb_ill, ex_f7;
    logic [3:0]  wb_rd;
    logic [31:0] wb_val, ex_v2, wb_dbg;

    // Drive one instruction from IDLE and capture EXEC and WB observations.
    task automatic run_instr(input logic [31:0] ins);
        int waits = 0;
        while (!instr_ready && waits < 10) begin
            @(negedge clk);
            waits++;
        end
        if (!instr_ready) begin
            total++;
            $display("FAIL accept_timeout instr=%h instr_ready=%b required 1", ins, instr_ready);
        end
        instr_valid = 1'b1;
        instr       = ins;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr       = $urandom;
        @(negedge clk);
        exec_done = done;
        ex_v2     = alu_value2;
        ex_f7     = alu_f7_bit;
        @(negedge clk);
        wb_done = done;
        wb_ill  = illegal;
        wb_rd   = done_rd;
        wb_val  = done_value;
        wb_dbg  = dbg_data;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        instr_valid = 1'b0;
        instr = 32'h0;
        dbg_addr = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #0.2;
        total++; if (instr_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", instr_ready); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else passed++;
        total++; if (illegal !== 1'b0) $display("FAIL reset_illegal got=%b exp=0", illegal); else passed++;
        total++; if (done_rd !== 4'd0) $display("FAIL reset_done_rd got=%0d exp=0", done_rd); else passed++;
        total++; if (done_value !== 32'd0) $display("FAIL reset_done_value got=%h exp=0", done_value); else passed++;
        total++; if ({alu_value1, alu_value2, alu_func_type, alu_f7_bit} !== 68'd0)
            $display("FAIL reset_alu_outs got=%h/%h/%0d/%b exp=0", alu_value1, alu_value2, alu_func_type, alu_f7_bit);
        else passed++;
        for (int i = 0; i < 16; i++) begin
            exp_regs[i] = 32'd0;
            dbg_addr = 4'(i);
            #0.2;
            total++; if (dbg_data !== 32'd0) $display("FAIL reset_reg x%0d got=%h exp=0", i, dbg_data); else passed++;
        end
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [3:0]  rd;
        logic [31:0] val;
        logic        f7;
        logic [31:0] v2;
    } vec_t;

    // Legal arithmetic, issued back to back so each one depends on the last writes.
    task automatic test_back_to_back();
        vec_t v [7];
        logic [31:0] old;
        v[0] = '{32'h00500093, 4'd1, 32'd5,        1'b0, 32'd5};        // ADDI x1,x0,5
        v[1] = '{32'h00108133, 4'd2, 32'd10,       1'b0, 32'd5};        // ADD  x2,x1,x1
        v[2] = '{32'h401001B3, 4'd3, 32'hFFFFFFFB, 1'b1, 32'd5};        // SUB  x3,x0,x1
        v[3] = '{32'h4011D213, 4'd4, 32'hFFFFFFFD, 1'b1, 32'h401};      // SRAI x4,x3,1
        v[4] = '{32'h40008393, 4'd7, 32'd1029,     1'b0, 32'h400};      // ADDI x7,x1,0x400
        v[5] = '{32'hFFF00413, 4'd8, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF}; // ADDI x8,x0,-1
        v[6] = '{32'h01008313, 4'd6, 32'd21,       1'b0, 32'd16};       // ADDI x6,x1,16
        for (int i = 0; i < 7; i++) begin
            dbg_addr = v[i].rd;
            old = exp_regs[v[i].rd];
            run_instr(v[i].ins);
            total++; if (exec_done !== 1'b0) $display("FAIL b2b%0d_exec_done got=%b exp=0", i, exec_done); else passed++;
            total++; if (ex_f7 !== v[i].f7) $display("FAIL b2b%0d_f7 got=%b exp=%b", i, ex_f7, v[i].f7); else passed++;
            total++; if (ex_v2 !== v[i].v2) $display("FAIL b2b%0d_value2 got=%h exp=%h", i, ex_v2, v[i].v2); else passed++;
            total++; if (wb_done !== 1'b1) $display("FAIL b2b%0d_done got=%b exp=1", i, wb_done); else passed++;
            total++; if (wb_ill !== 1'b0) $display("FAIL b2b%0d_illegal got=%b exp=0", i, wb_ill); else passed++;
            total++; if (wb_rd !== v[i].rd) $display("FAIL b2b%0d_done_rd got=%0d exp=%0d", i, wb_rd, v[i].rd); else passed++;
            total++; if (wb_val !== v[i].val) $display("FAIL b2b%0d_done_value got=%h exp=%h", i, wb_val, v[i].val); else passed++;
            total++; if (wb_dbg !== old) $display("FAIL b2b%0d_dbg_during_wb got=%h exp=%h", i, wb_dbg, old); else passed++;
            exp_regs[v[i].rd] = v[i].val;
            @(negedge clk);
            #0.2;
            total++; if (dbg_data !== v[i].val) $display("FAIL b2b%0d_dbg_after got=%h exp=%h", i, dbg_data, v[i].val); else passed++;
        end
    endtask

    // Rejected instructions and writes to x0 must leave the register file untouched.
    task automatic test_illegal();
        logic [31:0] bad [3];
        bad[0] = 32'h00100813;  // ADDI x16,x0,1 : rd outside RV32E
        bad[1] = 32'h00102083;  // LW x1,1(x0)   : unsupported opcode
        bad[2] = 32'h01008333;  // ADD x6,x1,x16 : rs2 outside RV32E
        for (int i = 0; i < 3; i++) begin
            run_instr(bad[i]);
            total++; if (wb_done !== 1'b1) $display("FAIL ill%0d_done got=%b exp=1", i, wb_done); else passed++;
            total++; if (wb_ill !== 1'b1) $display("FAIL ill%0d_illegal got=%b exp=1", i, wb_ill); else passed++;
            total++; if (wb_val !== 32'd0) $display("FAIL ill%0d_done_value got=%h exp=0", i, wb_val); else passed++;
        end
        run_instr(32'h00700013);  // ADDI x0,x0,7
        total++; if (wb_done !== 1'b1) $display("FAIL x0_done got=%b exp=1", wb_done); else passed++;
        total++; if (wb_ill !== 1'b0) $display("FAIL x0_illegal got=%b exp=0", wb_ill); else passed++;
        total++; if (wb_rd !== 4'd0) $display("FAIL x0_done_rd got=%0d exp=0", wb_rd); else passed++;
        total++; if (wb_val !== 32'd7) $display("FAIL x0_done_value got=%h exp=7", wb_val); else passed++;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i);
            #0.2;
            total++; if (dbg_data !== exp_regs[i]) $display("FAIL ill_regfile x%0d got=%h exp=%h", i, dbg_data, exp_regs[i]); else passed++;
        end
    endtask

    // SLLI with instr[30] set: rejected only when funct7 is strictly checked.
    task automatic test_f7_config();
        logic        exp_ill;
        logic [31:0] exp_val;
`ifdef ALU_ISSUE_STRICT_F7_EN
        exp_ill = 1'b1;
        exp_val = 32'd0;
`else
        exp_ill = 1'b0;
        exp_val = 32'd10;
`endif
        dbg_addr = 4'd5;
        run_instr(32'h40109293);  // SLLI x5,x1,1 with bit 30 set
        total++; if (ex_f7 !== 1'b0) $display("FAIL slli_f7 got=%b exp=0", ex_f7); else passed++;
        total++; if (wb_ill !== exp_ill) $display("FAIL slli_illegal got=%b exp=%b", wb_ill, exp_ill); else passed++;
        total++; if (wb_val !== exp_val) $display("FAIL slli_done_value got=%h exp=%h", wb_val, exp_val); else passed++;
        exp_regs[5] = exp_val;
        @(negedge clk);
        #0.2;
        total++; if (dbg_data !== exp_val) $display("FAIL slli_x5 got=%h exp=%h", dbg_data, exp_val); else passed++;
    endtask

    // Reset asserted during EXEC aborts the instruction and clears the register file.
    task automatic test_reset_mid();
        int done_seen = 0;
        instr_valid = 1'b1;
        instr       = 32'h00308493;  // ADDI x9,x1,3
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        total++; if (instr_ready !== 1'b1) $display("FAIL midrst_ready got=%b exp=1", instr_ready); else passed++;
        total++; if (done !== 1'b0) $display("FAIL midrst_done got=%b exp=0", done); else passed++;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        total++; if (done_seen != 0) $display("FAIL midrst_done_pulses got=%0d exp=0", done_seen); else passed++;
        for (int i = 0; i < 16; i++) begin
            exp_regs[i] = 32'd0;
            dbg_addr = 4'(i);
            #0.2;
            total++; if (dbg_data !== 32'd0) $display("FAIL midrst_reg x%0d got=%h exp=0", i, dbg_data); else passed++;
        end
    endtask

    // instr_valid held high: one accept every 3 cycles, each reading the last write.
    task automatic test_hold_valid();
        int accepts = 0;
        int dones = 0;
        instr_valid = 1'b1;
        instr       = 32'h00108093;  // ADDI x1,x1,1
        for (int i = 0; i < 9; i++) begin
            if (instr_ready === 1'b1) accepts++;
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        instr_valid = 1'b0;
        dbg_addr = 4'd1;
        #0.2;
        total++; if (accepts != 3) $display("FAIL hold_accepts got=%0d exp=3", accepts); else passed++;
        total++; if (dones != 3) $display("FAIL hold_dones got=%0d exp=3", dones); else passed++;
        total++; if (dbg_data !== 32'd3) $display("FAIL hold_x1 got=%h exp=3", dbg_data); else passed++;
        total++; if (instr_ready !== 1'b1) $display("FAIL hold_ready_end got=%b exp=1", instr_ready); else passed++;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        test_reset();
        test_back_to_back();
        test_illegal();
        test_f7_config();
        test_reset_mid();
        test_hold_valid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
